// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer for the EX stage.
// Owns the privilege mode and is the only writer of trap CSRs through one write port.
module trap_ctrl #(
  parameter int         XLEN     = 32,
  parameter logic [1:0] RST_PRIV = 2'b11
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mepc,
  output logic            req_ack,
  output logic            stall,
  output logic            csr_w_en,
  output logic [11:0]     csr_w_addr,
  output logic [XLEN-1:0] csr_w_data,
  output logic [1:0]      priv_mode,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  // state   | meaning
  // IDLE    | waiting for exception or mret
  // T_EPC   | trap: write mepc
  // T_CAUSE | trap: write mcause
  // T_TVAL  | trap: write mtval
  // T_STAT  | trap: write mstatus (stack MIE/priv)
  // T_RDR   | trap: redirect to trap vector
  // R_STAT  | mret: write mstatus (unstack MIE)
  // R_RDR   | mret: redirect to mepc, drop privilege
  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_RDR, R_STAT, R_RDR
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [1:0]  PRIV_M      = 2'b11;

  state_t          state, state_d;
  logic [XLEN-1:0] cause_q, tval_q, epc_q;
  logic [1:0]      prev_priv_q, mpp_q;
  logic            take_trap, take_mret;
  logic [XLEN-1:0] trap_stat, mret_stat, mtvec_base, vec_off;

  // mret outside M mode is an illegal instruction and takes the trap path
  assign take_trap = exc_valid | (mret_valid & (priv_mode != PRIV_M));
  assign take_mret = ~exc_valid & mret_valid & (priv_mode == PRIV_M);

  assign stall   = (state != IDLE) | exc_valid | mret_valid;
  assign req_ack = (state == IDLE) & (exc_valid | mret_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      priv_mode   <= RST_PRIV;
      cause_q     <= '0;
      tval_q      <= '0;
      epc_q       <= '0;
      prev_priv_q <= '0;
      mpp_q       <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && take_trap) begin
        cause_q     <= exc_valid ? exc_cause : XLEN'(2);
        tval_q      <= exc_valid ? exc_tval : '0;
        epc_q       <= ex_pc;
        prev_priv_q <= priv_mode;
        priv_mode   <= PRIV_M;
      end else if (state == IDLE && take_mret) begin
        mpp_q <= i_mstatus[12:11];
      end
      if (state == R_RDR) priv_mode <= mpp_q;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (take_trap)      state_d = T_EPC;
        else if (take_mret) state_d = R_STAT;
      end
      T_EPC:   state_d = T_CAUSE;
      T_CAUSE: state_d = T_TVAL;
      T_TVAL:  state_d = T_STAT;
      T_STAT:  state_d = T_RDR;
      T_RDR:   state_d = IDLE;
      R_STAT:  state_d = R_RDR;
      R_RDR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_w_en       = 1'b0;
    csr_w_addr     = '0;
    csr_w_data     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    trap_stat        = i_mstatus;
    trap_stat[12:11] = prev_priv_q;
    trap_stat[7]     = i_mstatus[3];
    trap_stat[3]     = 1'b0;

    mret_stat        = i_mstatus;
    mret_stat[3]     = i_mstatus[7];
    mret_stat[7]     = 1'b1;
    mret_stat[12:11] = 2'b00;

    mtvec_base = {i_mtvec[XLEN-1:2], 2'b00};
    vec_off    = {cause_q[XLEN-3:0], 2'b00};

    case (state)
      T_EPC: begin
        csr_w_en   = 1'b1;
        csr_w_addr = CSR_MEPC;
        csr_w_data = {epc_q[XLEN-1:2], 2'b00};
      end
      T_CAUSE: begin
        csr_w_en   = 1'b1;
        csr_w_addr = CSR_MCAUSE;
        csr_w_data = cause_q;
      end
      T_TVAL: begin
        csr_w_en   = 1'b1;
        csr_w_addr = CSR_MTVAL;
        csr_w_data = tval_q;
      end
      T_STAT: begin
        csr_w_en   = 1'b1;
        csr_w_addr = CSR_MSTATUS;
        csr_w_data = trap_stat;
      end
      T_RDR: begin
        redirect_valid = 1'b1;
        // vectored mode only applies to interrupts
        if (i_mtvec[1:0] == 2'b01 && cause_q[XLEN-1]) redirect_pc = mtvec_base + vec_off;
        else                                           redirect_pc = mtvec_base;
      end
      R_STAT: begin
        csr_w_en   = 1'b1;
        csr_w_addr = CSR_MSTATUS;
        csr_w_data = mret_stat;
      end
      R_RDR: begin
        redirect_valid = 1'b1;
        redirect_pc    = i_mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed literal scenarios, then random requests against a
// queue-based model of the per-cycle output sequence.
module tb_trap_ctrl;

  logic        clk, rstn;
  logic        exc_valid, mret_valid;
  logic [31:0] exc_cause, exc_tval, ex_pc, i_mtvec, i_mstatus, i_mepc;
  logic        req_ack, stall, csr_w_en, redirect_valid;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_data, redirect_pc;
  logic [1:0]  priv_mode;

  trap_ctrl #(.XLEN(32), .RST_PRIV(2'b11)) dut (
    .clk(clk), .rstn(rstn),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .ex_pc(ex_pc),
    .mret_valid(mret_valid), .i_mtvec(i_mtvec), .i_mstatus(i_mstatus), .i_mepc(i_mepc),
    .req_ack(req_ack), .stall(stall), .csr_w_en(csr_w_en), .csr_w_addr(csr_w_addr),
    .csr_w_data(csr_w_data), .priv_mode(priv_mode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected outputs for one busy cycle
  typedef struct {
    logic        w_en;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  priv;
  } exp_t;

  exp_t       q[$];
  logic [1:0] m_priv = 2'b11;
  exp_t       e;
  logic       e_stall, e_ack;

  function automatic exp_t mk(logic w, logic [11:0] a, logic [31:0] d, logic rv,
                              logic [31:0] rpc, logic [1:0] p);
    exp_t r;
    r.w_en = w; r.addr = a; r.data = d; r.rv = rv; r.rpc = rpc; r.priv = p;
    return r;
  endfunction

  task automatic push_trap(logic [31:0] c, logic [31:0] t, logic [31:0] pc, logic [1:0] prev);
    logic [31:0] stat, base, tgt;
    stat = (i_mstatus & ~32'h0000_1888) | ({30'd0, prev} << 11) | (i_mstatus[3] ? 32'h80 : 32'h0);
    base = i_mtvec & ~32'h3;
    tgt  = (i_mtvec[1:0] == 2'b01 && c[31]) ? base + (c & 32'h3FFF_FFFF) * 4 : base;
    q.push_back(mk(1'b1, 12'h341, pc & ~32'h3, 1'b0, 32'h0, 2'b11));
    q.push_back(mk(1'b1, 12'h342, c,           1'b0, 32'h0, 2'b11));
    q.push_back(mk(1'b1, 12'h343, t,           1'b0, 32'h0, 2'b11));
    q.push_back(mk(1'b1, 12'h300, stat,        1'b0, 32'h0, 2'b11));
    q.push_back(mk(1'b0, 12'h000, 32'h0,       1'b1, tgt,   2'b11));
    m_priv = 2'b11;
  endtask

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      m_priv  = 2'b11;
      e       = mk(1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 2'b11);
      e_stall = exc_valid | mret_valid;
      e_ack   = 1'b0;
    end else if (q.size() != 0) begin
      e       = q.pop_front();
      e_stall = 1'b1;
      e_ack   = 1'b0;
    end else begin
      e       = mk(1'b0, 12'h0, 32'h0, 1'b0, 32'h0, m_priv);
      e_stall = exc_valid | mret_valid;
      e_ack   = exc_valid | mret_valid;
      if (exc_valid)
        push_trap(exc_cause, exc_tval, ex_pc, m_priv);
      else if (mret_valid && m_priv != 2'b11)
        push_trap(32'd2, 32'd0, ex_pc, m_priv);
      else if (mret_valid) begin
        q.push_back(mk(1'b1, 12'h300,
                       (i_mstatus & ~32'h0000_1888) | 32'h80 | (i_mstatus[7] ? 32'h8 : 32'h0),
                       1'b0, 32'h0, 2'b11));
        q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, i_mepc, 2'b11));
        m_priv = i_mstatus[12:11];
      end
    end
    chk("m_req_ack", {31'd0, req_ack}, {31'd0, e_ack});
    chk("m_stall", {31'd0, stall}, {31'd0, e_stall});
    chk("m_csr_w_en", {31'd0, csr_w_en}, {31'd0, e.w_en});
    chk("m_csr_w_addr", {20'd0, csr_w_addr}, {20'd0, e.addr});
    chk("m_csr_w_data", csr_w_data, e.data);
    chk("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
    chk("m_redirect_pc", redirect_pc, e.rpc);
    chk("m_priv_mode", {30'd0, priv_mode}, {30'd0, e.priv});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string nm, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    chk({nm, "_wen"}, {31'd0, csr_w_en}, {31'd0, w});
    chk({nm, "_addr"}, {20'd0, csr_w_addr}, {20'd0, a});
    chk({nm, "_data"}, csr_w_data, d);
    chk({nm, "_rv"}, {31'd0, redirect_valid}, {31'd0, rv});
    chk({nm, "_rpc"}, redirect_pc, rpc);
    chk({nm, "_stall"}, {31'd0, stall}, 32'd1);
  endtask

  task automatic do_trap(input string nm, input logic [31:0] c, input logic [31:0] mt,
                         input logic [31:0] exp_pc);
    tick();
    exc_valid = 1'b1; exc_cause = c; exc_tval = 32'h0; ex_pc = 32'h100; i_mtvec = mt;
    @(negedge clk);
    chk({nm, "_ack"}, {31'd0, req_ack}, 32'd1);
    tick(); exc_valid = 1'b0;
    repeat (4) tick();
    chk_cyc({nm, "_rdr"}, 1'b0, 12'h0, 32'h0, 1'b1, exp_pc);
  endtask

  logic [31:0] rnd;

  initial begin
    rstn = 1'b0; exc_valid = 1'b0; mret_valid = 1'b0;
    exc_cause = '0; exc_tval = '0; ex_pc = '0; i_mtvec = '0; i_mstatus = '0; i_mepc = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_priv", {30'd0, priv_mode}, 32'd3);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wen", {31'd0, csr_w_en}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);

    // trap from M mode
    tick();
    exc_valid = 1'b1; exc_cause = 32'd2; exc_tval = 32'hDEAD; ex_pc = 32'h8000_0104;
    i_mtvec = 32'h8000_0000; i_mstatus = 32'h8;
    @(negedge clk);
    chk("trap_ack", {31'd0, req_ack}, 32'd1);
    chk("trap_stall0", {31'd0, stall}, 32'd1);
    tick(); exc_valid = 1'b0;
    chk_cyc("trap_epc", 1'b1, 12'h341, 32'h8000_0104, 1'b0, 32'h0);
    tick(); chk_cyc("trap_cause", 1'b1, 12'h342, 32'd2, 1'b0, 32'h0);
    tick(); chk_cyc("trap_tval", 1'b1, 12'h343, 32'hDEAD, 1'b0, 32'h0);
    tick(); chk_cyc("trap_stat", 1'b1, 12'h300, 32'h1880, 1'b0, 32'h0);
    tick(); chk_cyc("trap_rdr", 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_0000);
    tick(); @(negedge clk);
    chk("trap_done_stall", {31'd0, stall}, 32'd0);

    do_trap("vec_irq", 32'h8000_0007, 32'h8000_0001, 32'h8000_001C);
    do_trap("vec_exc", 32'd5, 32'h8000_0001, 32'h8000_0000);

    // legal mret, drops to S
    tick();
    mret_valid = 1'b1; i_mstatus = 32'h0880; i_mepc = 32'h2000;
    @(negedge clk);
    chk("mret_ack", {31'd0, req_ack}, 32'd1);
    tick(); mret_valid = 1'b0;
    chk_cyc("mret_stat", 1'b1, 12'h300, 32'h0088, 1'b0, 32'h0);
    tick(); chk_cyc("mret_rdr", 1'b0, 12'h0, 32'h0, 1'b1, 32'h2000);
    tick(); @(negedge clk);
    chk("mret_priv", {30'd0, priv_mode}, 32'd1);

    // mret from S is illegal
    tick();
    mret_valid = 1'b1; i_mstatus = 32'h0; ex_pc = 32'h3000; i_mtvec = 32'h100;
    @(negedge clk);
    chk("ill_ack", {31'd0, req_ack}, 32'd1);
    tick(); mret_valid = 1'b0;
    chk_cyc("ill_epc", 1'b1, 12'h341, 32'h3000, 1'b0, 32'h0);
    chk("ill_priv", {30'd0, priv_mode}, 32'd3);
    tick(); chk_cyc("ill_cause", 1'b1, 12'h342, 32'd2, 1'b0, 32'h0);
    tick(); chk_cyc("ill_tval", 1'b1, 12'h343, 32'd0, 1'b0, 32'h0);
    tick(); chk_cyc("ill_stat", 1'b1, 12'h300, 32'h0800, 1'b0, 32'h0);
    tick(); chk_cyc("ill_rdr", 1'b0, 12'h0, 32'h0, 1'b1, 32'h100);

    // simultaneous requests, ignored request, reset mid-sequence
    tick();
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 32'hB; exc_tval = 32'h1; ex_pc = 32'h44;
    @(negedge clk);
    chk("both_ack", {31'd0, req_ack}, 32'd1);
    tick(); exc_valid = 1'b0; mret_valid = 1'b0;
    chk_cyc("both_epc", 1'b1, 12'h341, 32'h44, 1'b0, 32'h0);
    tick(); mret_valid = 1'b1;
    chk_cyc("ign_cause", 1'b1, 12'h342, 32'hB, 1'b0, 32'h0);
    chk("ign_ack", {31'd0, req_ack}, 32'd0);
    tick(); mret_valid = 1'b0; rstn = 1'b0;
    #1;
    chk("arst_wen", {31'd0, csr_w_en}, 32'd0);
    chk("arst_priv", {30'd0, priv_mode}, 32'd3);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_addr", {20'd0, csr_w_addr}, 32'd0);
    tick(); rstn = 1'b1;

    // random phase; CSR inputs only change while the model says idle
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0; exc_valid = 1'b0; mret_valid = 1'b0;
        continue;
      end
      exc_valid  = ($urandom_range(0, 5) == 0);
      mret_valid = ($urandom_range(0, 3) == 0);
      exc_cause  = $urandom;
      exc_tval   = $urandom;
      ex_pc      = $urandom;
      if (q.size() == 0) begin
        rnd       = $urandom;
        i_mtvec   = {rnd[31:2], 1'b0, rnd[0]};
        i_mstatus = $urandom;
        i_mepc    = $urandom;
      end
    end
    tick();
    exc_valid = 1'b0; mret_valid = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap and mret sequencer in the EX stage. It sits directly upstream of the CSR register file and is the only agent that writes trap-related CSRs through its single write port.
- On an exception it saves mepc, mcause, mtval and mstatus over consecutive cycles, then redirects fetch to the trap vector.
- On mret it restores mstatus and privilege, then redirects fetch to mepc.
- It owns the current privilege mode and drives it to the CSR file.

Parameters:
- XLEN, 32, datapath width.
- RST_PRIV, 2'b11, privilege mode after reset.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- exc_valid  in  1  EX-stage exception request
- exc_cause  in  32  mcause value; bit 31 = interrupt
- exc_tval  in  32  mtval value
- ex_pc  in  32  PC of the trapping or mret instruction
- mret_valid  in  1  mret in EX
- i_mtvec  in  32  current mtvec from CSR file
- i_mstatus  in  32  current mstatus from CSR file
- i_mepc  in  32  current mepc from CSR file
- req_ack  out  1  request accepted this cycle
- stall  out  1  freeze pipeline
- csr_w_en  out  1  CSR write enable
- csr_w_addr  out  12  CSR write address
- csr_w_data  out  32  CSR write data
- priv_mode  out  2  current privilege (11 = M, 01 = S, 00 = U)
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  redirect target

Behaviour:
- Reset is asynchronous on rstn low. On reset:
  - state = IDLE, priv_mode = RST_PRIV.
  - All captured registers are 0.
  - csr_w_en = 0, redirect_valid = 0, req_ack = 0, stall = 0, csr_w_addr = 0, csr_w_data = 0, redirect_pc = 0.
  - Reset mid-sequence aborts it; no partial-write recovery.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_RDR, R_STAT, R_RDR.
- Requests are sampled only in IDLE. Requests arriving in any other state are ignored; the pipeline holds them because stall is high.
- stall = (state != IDLE) | exc_valid | mret_valid. It is combinational, so the pipeline freezes in the accept cycle.
- req_ack = 1 for exactly one cycle, in the IDLE cycle where a request is accepted.
- IDLE accept priority (exc_valid wins when both are high):
  - exc_valid = 1: capture cause = exc_cause, tval = exc_tval, epc = ex_pc, prev_priv = priv_mode. Set priv_mode <= 11. Go to T_EPC.
  - Else mret_valid = 1 and priv_mode != 11: treat as illegal instruction. Capture cause = 2, tval = 0, epc = ex_pc, prev_priv = priv_mode. Set priv_mode <= 11. Go to T_EPC.
  - Else mret_valid = 1 and priv_mode == 11: capture mpp = i_mstatus[12:11]. Go to R_STAT.
- Trap write sequence (one state per cycle, csr_w_en = 1 in each):
  - T_EPC: csr_w_addr = `MEPC (0x341), csr_w_data = {epc[31:2], 2'b00}.
  - T_CAUSE: csr_w_addr = `MCAUSE (0x342), csr_w_data = cause.
  - T_TVAL: csr_w_addr = `MTVAL (0x343), csr_w_data = tval.
  - T_STAT: csr_w_addr = `MSTATUS (0x300), csr_w_data = i_mstatus with:
    - MPP[12:11] = prev_priv
    - MPIE[7] = i_mstatus[3]
    - MIE[3] = 0
    - all other bits unchanged.
- T_RDR: csr_w_en = 0, redirect_valid = 1. Then go to IDLE.
  - Vectored target: if i_mtvec[1:0] == 01 and cause[31] == 1, redirect_pc = {i_mtvec[31:2], 2'b00} + (cause[29:0] << 2). The sum is truncated to 32 bits.
  - Otherwise redirect_pc = {i_mtvec[31:2], 2'b00}.
- R_STAT: csr_w_en = 1, csr_w_addr = `MSTATUS, csr_w_data = i_mstatus with:
  - MIE[3] = i_mstatus[7]
  - MPIE[7] = 1
  - MPP[12:11] = 00.
- R_RDR: redirect_valid = 1, redirect_pc = i_mepc. On exit, priv_mode <= mpp. Go to IDLE.
  - The mstatus write happens while priv is still M, so the CSR file accepts it.
- Latency: trap accept to redirect = 5 cycles (redirect in cycle accept+5). mret = 2 cycles.
- Outputs are combinational decodes of state and captured registers. In IDLE, csr_w_en = 0 and redirect_valid = 0.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after the redirect.
- A trap taken from M mode writes MPP = 11.

Test Plan:
- Reset, then check outputs: priv_mode = 11, stall = 0, csr_w_en = 0, redirect_valid = 0.
- Trap: exc_valid with cause = 2, tval = 0xDEAD, pc = 0x80000104, mtvec = 0x80000000, mstatus = 0x8 (from M mode).
  - req_ack in cycle 0.
  - Writes MEPC = 0x80000104, MCAUSE = 2, MTVAL = 0xDEAD, MSTATUS = 0x1880 in cycles 1–4.
  - Cycle 5: redirect_pc = 0x80000000.
  - stall high throughout cycles 0–5.
- Vectored trap: mtvec = 0x80000001, cause = 0x80000007 -> redirect_pc = 0x8000001C. Non-interrupt cause = 5 with the same mtvec -> redirect_pc = 0x80000000.
- mret in M mode: mstatus = 0x0880 (MPP = 01), mepc = 0x2000.
  - Cycle 1: writes MSTATUS = 0x0088.
  - Cycle 2: redirect to 0x2000.
  - After cycle 2: priv_mode = 01.
- mret from S mode -> illegal-instruction trap: MCAUSE = 2, MTVAL = 0, MSTATUS MPP = 01, priv_mode = 11.
- Simultaneous exc_valid and mret_valid -> trap path taken. Request asserted during T_CAUSE is ignored. Assert rstn low during T_TVAL -> state IDLE, priv_mode = 11, csr_w_en = 0 immediately.
